// File: rtl/instruction_fetch_pkg.sv
// Shared widths, timeout limit and state encoding for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam int ADDR_W        = 13;
  localparam int INSTR_W       = 8;
  localparam int FETCH_TIMEOUT = 15;
  localparam int WAIT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: jump load has priority over increment; increment wraps modulo 2**ADDR_W.
module program_counter
  import instruction_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetches one instruction per request; ir_valid two edges after acceptance with zero-wait memory.
// Holds mem_rd until mem_ack; 16 READ cycles without ack park the unit in ERROR until err_clr.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               err_clr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_err
);

  fetch_state_t        state, state_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nx;
  logic                pc_load, pc_inc, ir_load;

  program_counter u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  assign mem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A same-edge jump lands in pc before READ starts, so the fetch reads jump_addr.
        pc_load = jump_en;
        if (fetch_req) begin
          state_nx    = ST_READ;
          wait_cnt_nx = '0;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          ir_load  = 1'b1;
          pc_inc   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_W'(FETCH_TIMEOUT)) begin
            state_nx = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (err_clr) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir        <= '0;
      ir_valid  <= 1'b0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      if (ir_load) begin
        ir <= mem_rdata;
      end
      ir_valid  <= ir_load;
      mem_rd    <= (state_nx == ST_READ);
      busy      <= (state_nx == ST_READ);
      fetch_err <= (state_nx == ST_ERROR);
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have one clock, clk: input, 1 bit, rising-edge clock for all state.
REQ-002 The module SHALL have reset rst: input, 1 bit, asynchronous, active-low; rst=0 resets all state immediately.
REQ-003 The module SHALL have fetch_req: input, 1 bit, a request from the controller to fetch the next instruction; it is sampled only in IDLE.
REQ-004 The module SHALL have jump_en: input, 1 bit, and jump_addr: input, 13 bits, which redirect the PC; they are sampled only in IDLE.
REQ-005 The module SHALL have err_clr: input, 1 bit, which clears the fetch error; it is sampled only in ERROR.
REQ-006 The module SHALL have mem_addr: output, 13 bits, the memory read address.
REQ-007 The module SHALL have mem_rd: output, 1 bit, the memory read strobe, held high until acknowledge.
REQ-008 The module SHALL have mem_rdata: input, 8 bits, memory read data, valid when mem_ack=1.
REQ-009 The module SHALL have mem_ack: input, 1 bit, the memory acknowledge, single-cycle.
REQ-010 The module SHALL have ir: output, 8 bits, the instruction register; ir[3:0] is the opcode field consumed by the controller.
REQ-011 The module SHALL have ir_valid: output, 1 bit, a one-cycle pulse when ir holds a newly fetched instruction.
REQ-012 The module SHALL have pc: output, 13 bits, the program counter.
REQ-013 The module SHALL have busy: output, 1 bit, high while in READ.
REQ-014 The module SHALL have fetch_err: output, 1 bit, high while in ERROR.

Function
REQ-015 The FSM SHALL have three states: IDLE, READ and ERROR.
REQ-016 In IDLE with fetch_req=1, the FSM SHALL move to READ on the next edge; mem_rd SHALL be 1 from the following cycle.
REQ-017 In IDLE with jump_en=1, pc SHALL load jump_addr on that edge, whether or not fetch_req is also high.
REQ-018 When jump_en and fetch_req are both high in IDLE, the fetch SHALL read from jump_addr.
REQ-019 In READ, mem_addr SHALL equal pc, and pc SHALL be stable throughout READ.
REQ-020 In READ with mem_ack=1, on that edge: ir <= mem_rdata; pc <= pc+1 modulo 8192 (8191 wraps to 0); ir_valid <= 1 for exactly one cycle; state <= IDLE.
REQ-021 Latency SHALL be: request accepted at edge N; with zero-wait memory (ack in first READ cycle), ir_valid is high in cycle N+2.
REQ-022 ir_valid SHALL be 0 in every other cycle.
REQ-023 A fetch_req that is high while ir_valid=1 (IDLE) SHALL be accepted, giving back-to-back fetches.
REQ-024 A 4-bit wait counter SHALL clear on entry to READ and increment each READ cycle in which mem_ack=0.
REQ-025 When the wait counter is at 15 and mem_ack=0, the FSM SHALL move to ERROR; the timeout is the 16th cycle without acknowledge.
REQ-026 On timeout, pc and ir SHALL be unchanged and mem_rd SHALL go 0.
REQ-027 When mem_ack=1 in the same cycle the counter reaches 15, the acknowledge SHALL win and the fetch SHALL complete normally.
REQ-028 ERROR SHALL persist until err_clr=1, then the FSM SHALL move to IDLE.
REQ-029 fetch_req and jump_en SHALL be ignored in READ and ERROR.
REQ-030 mem_ack SHALL be ignored outside READ.
REQ-031 mem_rd SHALL be 0 in IDLE and ERROR.
REQ-032 busy SHALL be 1 only in READ.
REQ-033 fetch_err SHALL be 1 only in ERROR.

Reset
REQ-034 rst=0 SHALL asynchronously force: state IDLE, pc=0, ir=0, wait counter 0, ir_valid=0, mem_rd=0, busy=0, fetch_err=0; mem_addr then follows pc=0.
REQ-035 Reset asserted mid-READ SHALL abandon the access with no ir or pc update; mem_rd SHALL drop in the same cycle reset asserts.
REQ-036 After reset release, the first edge SHALL see IDLE.

Structure
REQ-037 The state encoding, ADDR_W=13, INSTR_W=8 and FETCH_TIMEOUT=15 SHALL live in the shared defines package.
REQ-038 The program counter (load, increment, wrap) SHALL be one sub-module, program_counter.
REQ-039 All outputs except mem_addr SHALL be registered.

Verification
REQ-040 Scenario: reset, then fetch_req with memory returning 0x3A with zero wait -> ir=0x3A, ir_valid pulse in cycle N+2, pc=1.
REQ-041 Scenario: jump_en with jump_addr=0x1FFF together with fetch_req, memory returning 0xC5 -> mem_addr=0x1FFF during READ, ir=0xC5, pc wraps to 0.
REQ-042 Scenario: ack delayed 5 cycles -> mem_rd high for 6 cycles, busy high, mem_addr stable; then ir_valid pulses once.
REQ-043 Scenario: no ack -> fetch_err after 16 READ cycles, pc unchanged; err_clr returns IDLE; a later fetch succeeds.
REQ-044 Scenario: ack coincident with the 16th wait cycle -> normal completion, fetch_err=0.
REQ-045 Scenario: rst=0 mid-READ (pc=0x0042) -> pc=0, ir=0, mem_rd=0 immediately; a late mem_ack after release has no effect.
